// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared pipeline constants and types for hazard control
package pipe_hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/fwd_sel.sv
// rtl/fwd_sel.sv - ALU operand forwarding select for one source register
module fwd_sel
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [4:0] src_i,
  input  logic [4:0] mem_wra_i,
  input  logic       mem_we_i,
  input  logic [4:0] wb_wra_i,
  input  logic       wb_we_i,
  output logic [1:0] sel_o
);

  // MEM holds the younger result, so it wins over WB
  always_comb begin
    sel_o = FWD_RF;
    if (mem_we_i && (mem_wra_i != REG_ZERO) && (mem_wra_i == src_i)) begin
      sel_o = FWD_MEM;
    end else if (wb_we_i && (wb_wra_i != REG_ZERO) && (wb_wra_i == src_i)) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - load-use/branch hazard detection, mul/div sequencing and forwarding
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MD_CYCLES = 32,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_useRs,
  input  logic             id_useRt,
  input  logic [4:0]       exe_rs,
  input  logic [4:0]       exe_rt,
  input  logic [4:0]       exe_WRA,
  input  logic             exe_regWe,
  input  logic             exe_isLoad,
  input  logic             exe_mdStart,
  input  logic             exe_clr,
  input  logic [4:0]       mem_WRA,
  input  logic             mem_regWe,
  input  logic [4:0]       wb_WRA,
  input  logic             wb_regWe,
  output logic             pc_pause,
  output logic             id_pause,
  output logic             exe_pause,
  output logic             id_flush,
  output logic             exe_bubble,
  output logic [1:0]       fwdA,
  output logic [1:0]       fwdB,
  output logic             md_busy,
  output logic             md_we,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int CW = $clog2(MD_CYCLES);

  md_state_e        state_q;
  logic [CW-1:0]    cnt_q;
  logic             md_busy_q;
  logic             md_we_q;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic [1:0] fwd_a, fwd_b;
  logic       in_idle, load_use, branch, lu_stall, pause_c;

  fwd_sel u_fwd_a (
    .src_i     (exe_rs),
    .mem_wra_i (mem_WRA),
    .mem_we_i  (mem_regWe),
    .wb_wra_i  (wb_WRA),
    .wb_we_i   (wb_regWe),
    .sel_o     (fwd_a)
  );

  fwd_sel u_fwd_b (
    .src_i     (exe_rt),
    .mem_wra_i (mem_WRA),
    .mem_we_i  (mem_regWe),
    .wb_wra_i  (wb_WRA),
    .wb_we_i   (wb_regWe),
    .sel_o     (fwd_b)
  );

  always_comb begin
    in_idle  = (state_q == ST_IDLE);
    load_use = exe_isLoad && exe_regWe && (exe_WRA != REG_ZERO) &&
               ((id_useRs && (id_rs == exe_WRA)) || (id_useRt && (id_rt == exe_WRA)));
    branch   = in_idle && exe_clr;
    // a taken branch squashes the dependent instr, so its stall is moot
    lu_stall = in_idle && load_use && !exe_clr;
    pause_c  = lu_stall || md_busy_q;
  end

  // Outputs are forced low while reset is asserted, not just after the next edge
  assign pc_pause   = rstn && pause_c;
  assign id_pause   = rstn && pause_c;
  assign exe_pause  = rstn && md_busy_q;
  assign id_flush   = rstn && branch;
  assign exe_bubble = rstn && (branch || lu_stall);
  assign fwdA       = rstn ? fwd_a : FWD_RF;
  assign fwdB       = rstn ? fwd_b : FWD_RF;
  assign md_busy    = md_busy_q;
  assign md_we      = md_we_q;
  assign stall_cnt  = stall_q;

  // BUSY lasts MD_CYCLES-2 cycles; with MD_CYCLES==2 the op goes straight to DONE
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      md_busy_q <= 1'b0;
      md_we_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (exe_mdStart) begin
            cnt_q <= CW'(MD_CYCLES - 2);
            if (MD_CYCLES == 2) begin
              state_q <= ST_DONE;
              md_we_q <= 1'b1;
            end else begin
              state_q   <= ST_BUSY;
              md_busy_q <= 1'b1;
            end
          end
        end
        ST_BUSY: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q <= CW'(1)) begin
            state_q   <= ST_DONE;
            md_busy_q <= 1'b0;
            md_we_q   <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          md_we_q <= 1'b0;
        end
        default: begin
          state_q   <= ST_IDLE;
          md_busy_q <= 1'b0;
          md_we_q   <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (pause_c && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed vector bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic [4:0] id_rs, id_rt, exe_rs, exe_rt, exe_WRA, mem_WRA, wb_WRA;
  logic       id_useRs, id_useRt, exe_regWe, exe_isLoad, exe_mdStart, exe_clr;
  logic       mem_regWe, wb_regWe;
  logic       pc_pause, id_pause, exe_pause, id_flush, exe_bubble, md_busy, md_we;
  logic [1:0] fwdA, fwdB;
  logic [3:0] stall_cnt;
  logic [10:0] out_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MD_CYCLES(4), .CNT_W(4)) dut (
    .clk(clk), .rstn(rstn),
    .id_rs(id_rs), .id_rt(id_rt), .id_useRs(id_useRs), .id_useRt(id_useRt),
    .exe_rs(exe_rs), .exe_rt(exe_rt), .exe_WRA(exe_WRA), .exe_regWe(exe_regWe),
    .exe_isLoad(exe_isLoad), .exe_mdStart(exe_mdStart), .exe_clr(exe_clr),
    .mem_WRA(mem_WRA), .mem_regWe(mem_regWe), .wb_WRA(wb_WRA), .wb_regWe(wb_regWe),
    .pc_pause(pc_pause), .id_pause(id_pause), .exe_pause(exe_pause),
    .id_flush(id_flush), .exe_bubble(exe_bubble), .fwdA(fwdA), .fwdB(fwdB),
    .md_busy(md_busy), .md_we(md_we), .stall_cnt(stall_cnt)
  );

  // {fwdA, fwdB, pc_pause, id_pause, exe_pause, id_flush, exe_bubble, md_busy, md_we}
  assign out_w = {fwdA, fwdB, pc_pause, id_pause, exe_pause, id_flush, exe_bubble, md_busy, md_we};

  // flags: {useRs, useRt, exe_regWe, exe_isLoad, exe_clr, mem_regWe, wb_regWe, exe_mdStart}
  typedef struct {
    string      name;
    logic [4:0] id_rs, id_rt, exe_rs, exe_rt, exe_wra, mem_wra, wb_wra;
    logic [7:0] flags;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    id_rs = v.id_rs; id_rt = v.id_rt; exe_rs = v.exe_rs; exe_rt = v.exe_rt;
    exe_WRA = v.exe_wra; mem_WRA = v.mem_wra; wb_WRA = v.wb_wra;
    {id_useRs, id_useRt, exe_regWe, exe_isLoad, exe_clr, mem_regWe, wb_regWe, exe_mdStart} = v.flags;
  endtask

  task automatic idle();
    vec_t z;
    z = '{"idle", 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 8'h00, 11'd0};
    drive(z);
  endtask

  logic seen_md;

  initial begin
    vecs[0]  = '{"fwd_mem_prio", 5'd0, 5'd0, 5'd5, 5'd7, 5'd0, 5'd5, 5'd5, 8'b00000110, 11'b01_00_0000000};
    vecs[1]  = '{"fwd_mem_r0",   5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 8'b00000100, 11'b00_00_0000000};
    vecs[2]  = '{"fwd_split",    5'd0, 5'd0, 5'd5, 5'd7, 5'd0, 5'd5, 5'd7, 8'b00000110, 11'b01_10_0000000};
    vecs[3]  = '{"fwd_wb_only",  5'd0, 5'd0, 5'd5, 5'd5, 5'd0, 5'd5, 5'd5, 8'b00000010, 11'b10_10_0000000};
    vecs[4]  = '{"lu_rt",        5'd1, 5'd3, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 8'b01110000, 11'b00_00_1100100};
    vecs[5]  = '{"lu_unused",    5'd1, 5'd3, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 8'b10110000, 11'b00_00_0000000};
    vecs[6]  = '{"lu_r0",        5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 8'b11110000, 11'b00_00_0000000};
    vecs[7]  = '{"alu_no_stall", 5'd0, 5'd3, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 8'b01100000, 11'b00_00_0000000};
    vecs[8]  = '{"clr_over_lu",  5'd1, 5'd3, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 8'b01111000, 11'b00_00_0001100};
    vecs[9]  = '{"clr_only",     5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 8'b00001000, 11'b00_00_0001100};
    vecs[10] = '{"lu_rs",        5'd9, 5'd2, 5'd0, 5'd0, 5'd9, 5'd0, 5'd0, 8'b10110000, 11'b00_00_1100100};
    vecs[11] = '{"lu_and_fwd",   5'd0, 5'd4, 5'd6, 5'd8, 5'd4, 5'd6, 5'd8, 8'b01110110, 11'b01_10_1100100};

    // reset with hazards driven on every input: outputs must still be quiet
    rstn = 1'b0;
    drive(vecs[11]);
    exe_mdStart = 1'b1;
    exe_clr = 1'b1;
    #1;
    chk("reset_outputs", 32'(out_w), 32'd0);
    chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    idle();
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk(vecs[i].name, 32'(out_w), 32'(vecs[i].exp));
    end

    // three single-cycle load-use stalls in the table
    @(negedge clk);
    idle();
    #1;
    chk("lu_self_clear", 32'(out_w), 32'd0);
    chk("stall_cnt_lu", 32'(stall_cnt), 32'd3);

    // mul/div with MD_CYCLES=4; start held high and a branch in BUSY must be ignored
    @(negedge clk); idle(); exe_mdStart = 1'b1; #1;
    chk("md_c1", 32'(out_w), 32'd0);
    @(negedge clk); exe_clr = 1'b1; #1;
    chk("md_c2", 32'(out_w), 32'(11'b00_00_1110010));
    @(negedge clk); exe_clr = 1'b0; drive(vecs[4]); exe_mdStart = 1'b1; #1;
    chk("md_c3", 32'(out_w), 32'(11'b00_00_1110010));
    @(negedge clk); idle(); exe_mdStart = 1'b1; #1;
    chk("md_c4_we", 32'(out_w), 32'(11'b00_00_0000001));
    @(negedge clk); exe_mdStart = 1'b0; #1;
    chk("md_c5_idle", 32'(out_w), 32'd0);
    @(negedge clk); #1;
    chk("md_c6_no_restart", 32'(out_w), 32'd0);
    chk("stall_cnt_md", 32'(stall_cnt), 32'd5);

    // reset while BUSY aborts the op
    @(negedge clk); exe_mdStart = 1'b1;
    @(negedge clk); exe_mdStart = 1'b0; #1;
    chk("abort_busy", 32'(out_w), 32'(11'b00_00_1110010));
    @(negedge clk); rstn = 1'b0; drive(vecs[8]); #1;
    chk("abort_outputs", 32'(out_w), 32'd0);
    chk("abort_stall_cnt", 32'(stall_cnt), 32'd0);
    @(negedge clk); idle();
    @(negedge clk); rstn = 1'b1;
    seen_md = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seen_md = seen_md | md_we | md_busy;
    end
    chk("abort_no_md_we", 32'(seen_md), 32'd0);

    // 20 stalled cycles saturate a 4-bit counter at 15
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(vecs[4]);
      #1;
      if (i == 15) chk("sat_reach_15", 32'(stall_cnt), 32'd15);
      if (i == 19) chk("sat_pause_19", 32'(pc_pause), 32'd1);
    end
    @(negedge clk); idle(); #1;
    chk("sat_hold_15", 32'(stall_cnt), 32'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
